// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, round constants and word helpers.
// Used by the forward and inverse round-key steps.
package aes_pkg;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_key_t;

    typedef enum logic [1:0] {
        IDLE,
        LIN,
        SUB,
        FIN
    } state_t;

    // Indexed directly by the 4-bit round count; unused slots are zero.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04,
        8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
// Shared by the forward and inverse key-schedule steps.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_o = SBOX[in_i];

endmodule

// File: rtl/inv_round_key_tf.sv
// Inverse AES-128 key-schedule step: K_r -> K_{r-1}.
// Define INV_RKEY_PARALLEL_SBOX_EN for four S-boxes and a 2-clock path.
module inv_round_key_tf
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_i,
    input  logic [3:0]   round_count_i,
    output logic [127:0] key_o,
    output logic         done_o,
    output logic         busy_o,
    output logic         err_o
);

    localparam logic [3:0] MAX_R = 4'(NUM_ROUNDS);

    state_t    state_q, state_d;
    aes_key_t  w_q, w_d;
    aes_key_t  key_q, key_d;
    logic [3:0] rnd_q, rnd_d;
    logic      err_q, err_d;
    logic [1:0] cnt_q, cnt_d;
    aes_word_t tmp_q, tmp_d;
    logic      done_q, done_d;
    logic      erro_q, erro_d;

    aes_word_t rw;
    aes_word_t sub_w;
    logic      accept;
    logic      legal;

    assign rw = rot_word(w_q[31:0]);

`ifdef INV_RKEY_PARALLEL_SBOX_EN
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (rw[8*i +: 8]),
            .out_o (sub_w[8*i +: 8])
        );
    end
`else
    logic [7:0] sb_in;
    logic [7:0] sb_out;

    always_comb begin
        sb_in = rw[31:24];
        unique case (cnt_q)
            2'd0: sb_in = rw[31:24];
            2'd1: sb_in = rw[23:16];
            2'd2: sb_in = rw[15:8];
            2'd3: sb_in = rw[7:0];
        endcase
    end

    aes_sbox u_sbox (
        .in_i  (sb_in),
        .out_o (sb_out)
    );

    assign sub_w = tmp_q;
`endif

    assign legal  = (round_count_i != 4'd0) && (round_count_i <= MAX_R);
    // The done cycle is still treated as busy for start acceptance.
    assign accept = (state_q == IDLE) && !done_q && start;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        tmp_d   = tmp_q;
        done_d  = 1'b0;
        erro_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    w_d     = key_i;
                    rnd_d   = round_count_i;
                    err_d   = !legal;
                    state_d = LIN;
                end
            end
            LIN: begin
                if (!err_q) begin
                    w_d = {w_q[127:96],
                           w_q[95:64] ^ w_q[127:96],
                           w_q[63:32] ^ w_q[95:64],
                           w_q[31:0]  ^ w_q[63:32]};
                end
                cnt_d = 2'd0;
`ifdef INV_RKEY_PARALLEL_SBOX_EN
                state_d = FIN;
`else
                state_d = err_q ? FIN : SUB;
`endif
            end
            SUB: begin
`ifndef INV_RKEY_PARALLEL_SBOX_EN
                tmp_d = {tmp_q[23:0], sb_out};
`endif
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (err_q) begin
                    key_d = w_q;
                end else begin
                    key_d = {w_q[127:96] ^ sub_w ^ {RCON[rnd_q], 24'h0},
                             w_q[95:0]};
                end
                done_d  = 1'b1;
                erro_d  = err_q;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            tmp_q   <= '0;
            done_q  <= 1'b0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            tmp_q   <= tmp_d;
            done_q  <= done_d;
            erro_q  <= erro_d;
        end
    end

    assign key_o  = key_q;
    assign done_o = done_q;
    assign err_o  = erro_q;
    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_inv_round_key_tf.sv
// Directed bench for the inverse AES-128 round-key step.
// Known FIPS-197 schedule vectors, latency, errors, restart and reset.
module tb_inv_round_key_tf;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_i = '0;
    logic [3:0]   round_count_i = '0;
    logic [127:0] key_o;
    logic         done_o;
    logic         busy_o;
    logic         err_o;

    int nerr = 0;
    int nchk = 0;

`ifdef INV_RKEY_PARALLEL_SBOX_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 6;
`endif

    localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] K2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KX  = 128'h000102030405060708090a0b0c0d0e0f;

    always #5 clk = ~clk;

    inv_round_key_tf dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .key_i         (key_i),
        .round_count_i (round_count_i),
        .key_o         (key_o),
        .done_o        (done_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    task automatic run(input logic [127:0] k, input logic [3:0] r,
                       output int lat, output logic [127:0] ko,
                       output logic eo, output logic one,
                       output logic bsy);
        @(negedge clk);
        key_i = k;
        round_count_i = r;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key_i = '1;
        round_count_i = 4'd0;
        bsy = busy_o;
        lat = 0;
        ko = '0;
        eo = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done_o) begin
                lat = n;
                break;
            end
        end
        ko = key_o;
        eo = err_o;
        @(negedge clk);
        one = !done_o;
    endtask

    task automatic test_reset();
        nchk += 4;
        if (key_o !== '0) begin
            nerr++;
            $display("FAIL reset_key got=%h exp=0", key_o);
        end
        if (done_o !== 1'b0) begin
            nerr++;
            $display("FAIL reset_done got=%b exp=0", done_o);
        end
        if (busy_o !== 1'b0) begin
            nerr++;
            $display("FAIL reset_busy got=%b exp=0", busy_o);
        end
        if (err_o !== 1'b0) begin
            nerr++;
            $display("FAIL reset_err got=%b exp=0", err_o);
        end
    endtask

    task automatic test_round10();
        int lat;
        logic [127:0] ko;
        logic eo, one, bsy;
        run(K10, 4'd10, lat, ko, eo, one, bsy);
        nchk += 5;
        if (lat !== LAT) begin
            nerr++;
            $display("FAIL r10_latency got=%0d exp=%0d", lat, LAT);
        end
        if (ko !== K9) begin
            nerr++;
            $display("FAIL r10_key got=%h exp=%h", ko, K9);
        end
        if (eo !== 1'b0) begin
            nerr++;
            $display("FAIL r10_err got=%b exp=0", eo);
        end
        if (one !== 1'b1) begin
            nerr++;
            $display("FAIL r10_done_width got=%b exp=1", one);
        end
        if (bsy !== 1'b1) begin
            nerr++;
            $display("FAIL r10_busy got=%b exp=1", bsy);
        end
    endtask

    task automatic test_round1();
        int lat;
        logic [127:0] ko;
        logic eo, one, bsy;
        run(K1, 4'd1, lat, ko, eo, one, bsy);
        nchk += 2;
        if (ko !== K0) begin
            nerr++;
            $display("FAIL r1_key got=%h exp=%h", ko, K0);
        end
        if (busy_o !== 1'b0) begin
            nerr++;
            $display("FAIL r1_busy_after got=%b exp=0", busy_o);
        end
    endtask

    task automatic test_chain();
        int lat;
        logic [127:0] ko, k;
        logic eo, one, bsy;
        k = K10;
        for (int r = 10; r >= 1; r--) begin
            run(k, 4'(r), lat, ko, eo, one, bsy);
            k = ko;
            nchk++;
            if (one !== 1'b1 || lat !== LAT) begin
                nerr++;
                $display("FAIL chain_done r=%0d lat=%0d one=%b exp lat=%0d one=1",
                         r, lat, one, LAT);
            end
            if (r == 2) begin
                nchk++;
                if (ko !== K1) begin
                    nerr++;
                    $display("FAIL chain_r2 got=%h exp=%h", ko, K1);
                end
            end
        end
        nchk++;
        if (k !== K0) begin
            nerr++;
            $display("FAIL chain_final got=%h exp=%h", k, K0);
        end
    endtask

    task automatic test_illegal();
        int lat;
        logic [127:0] ko;
        logic eo, one, bsy;
        logic [3:0] rs [2];
        rs[0] = 4'd0;
        rs[1] = 4'd11;
        for (int i = 0; i < 2; i++) begin
            run(KX ^ 128'(i), rs[i], lat, ko, eo, one, bsy);
            nchk += 3;
            if (lat !== 2) begin
                nerr++;
                $display("FAIL illegal_lat r=%0d got=%0d exp=2", rs[i], lat);
            end
            if (eo !== 1'b1) begin
                nerr++;
                $display("FAIL illegal_err r=%0d got=%b exp=1", rs[i], eo);
            end
            if (ko !== (KX ^ 128'(i))) begin
                nerr++;
                $display("FAIL illegal_key r=%0d got=%h exp=%h",
                         rs[i], ko, KX ^ 128'(i));
            end
        end
    endtask

    task automatic test_restart_ignored();
        int dones;
        logic [127:0] first;
        dones = 0;
        first = '0;
        @(negedge clk);
        key_i = K10;
        round_count_i = 4'd10;
        start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_o) begin
                dones++;
                if (dones == 1) first = key_o;
            end
            start = done_o || (c == 1) || (c == 3);
            key_i = K1;
            round_count_i = 4'd1;
        end
        start = 1'b0;
        nchk += 2;
        if (dones !== 1) begin
            nerr++;
            $display("FAIL restart_done_count got=%0d exp=1", dones);
        end
        if (first !== K9) begin
            nerr++;
            $display("FAIL restart_key got=%h exp=%h", first, K9);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        int lat;
        logic [127:0] ko;
        logic eo, one, bsy;
        @(negedge clk);
        key_i = K10;
        round_count_i = 4'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        nchk += 2;
        if (key_o !== '0) begin
            nerr++;
            $display("FAIL midrst_key got=%h exp=0", key_o);
        end
        if (busy_o !== 1'b0) begin
            nerr++;
            $display("FAIL midrst_busy got=%b exp=0", busy_o);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        nchk++;
        if (dones !== 0) begin
            nerr++;
            $display("FAIL midrst_no_done got=%0d exp=0", dones);
        end
        run(K2, 4'd2, lat, ko, eo, one, bsy);
        nchk++;
        if (ko !== K1) begin
            nerr++;
            $display("FAIL midrst_after got=%h exp=%h", ko, K1);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_round10();
        test_round1();
        test_chain();
        test_illegal();
        test_restart_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
